// File: rtl/frame_config_sequencer_if.sv
// rtl/frame_config_sequencer_if.sv - configuration word stream between bitstream source and frame sequencer
interface frame_config_sequencer_if #(
   parameter int W = 32
);
   logic [W-1:0] cfg_word;
   logic         cfg_valid;
   logic         cfg_ready;

   modport master (output cfg_word, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// rtl/frame_config_sequencer.sv - assembles one multi-row configuration frame and fires its one-hot frame strobe
module frame_config_sequencer #(
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 2,
   parameter int MaxFramesPerCol = 20
) (
   input  logic                                 CLK,
   input  logic                                 reset,
   frame_config_sequencer_if.slave              cfg,
   output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic [15:0]                          frames_written,
   output logic                                 err_sync,
   output logic                                 err_range,
   input  logic                                 err_clr
);
   localparam int         RowW     = $clog2(NumRows + 1);
   localparam logic [7:0] SyncByte = 8'hFA;

   typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD, DRAIN} state_t;

   state_t          state, state_next;
   logic [RowW-1:0] row;
   logic [7:0]      idx;
   logic            accept;
   logic            hdr_sync_ok;
   logic            hdr_in_range;
   logic            last_row;
   logic            set_sync;
   logic            set_range;

   assign accept       = cfg.cfg_valid & cfg.cfg_ready;
   assign hdr_sync_ok  = (cfg.cfg_word[31:24] == SyncByte);
   assign hdr_in_range = (cfg.cfg_word[23:16] < 8'(MaxFramesPerCol));
   assign last_row     = (row == RowW'(NumRows - 1));
   assign busy         = (state != IDLE);

   // cfg_ready is a pure state decode, so cfg_valid alone qualifies acceptance here
   always_comb begin
      state_next    = state;
      cfg.cfg_ready = 1'b0;
      FrameStrobe   = '0;
      set_sync      = 1'b0;
      set_range     = 1'b0;
      case (state)
         IDLE: begin
            cfg.cfg_ready = 1'b1;
            if (cfg.cfg_valid) begin
               if (!hdr_sync_ok) begin
                  set_sync = 1'b1;
               end else if (hdr_in_range) begin
                  state_next = LOAD;
               end else begin
                  set_range  = 1'b1;
                  state_next = DRAIN;
               end
            end
         end
         LOAD: begin
            cfg.cfg_ready = 1'b1;
            if (cfg.cfg_valid && last_row) state_next = STROBE;
         end
         STROBE: begin
            FrameStrobe = MaxFramesPerCol'(1) << idx;
            state_next  = HOLD;
         end
         HOLD: state_next = IDLE;
         DRAIN: begin
            cfg.cfg_ready = 1'b1;
            if (cfg.cfg_valid && last_row) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state          <= IDLE;
         row            <= '0;
         idx            <= '0;
         FrameData      <= '0;
         frames_written <= '0;
         err_sync       <= 1'b0;
         err_range      <= 1'b0;
      end else begin
         state     <= state_next;
         // a new error in the same cycle as err_clr must survive the clear
         err_sync  <= set_sync  | (err_sync  & ~err_clr);
         err_range <= set_range | (err_range & ~err_clr);
         case (state)
            IDLE: if (accept) begin
               row <= '0;
               idx <= cfg.cfg_word[23:16];
            end
            LOAD: if (accept) begin
               FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= cfg.cfg_word;
               row <= row + 1'b1;
            end
            DRAIN: if (accept) row <= row + 1'b1;
            STROBE: if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_frame_config_sequencer.sv
// tb/tb_frame_config_sequencer.sv - directed scoreboard bench for frame_config_sequencer
module tb_frame_config_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        err_clr = 1'b0;
   logic [63:0] FrameData;
   logic [19:0] FrameStrobe;
   logic        busy;
   logic [15:0] frames_written;
   logic        err_sync;
   logic        err_range;

   typedef struct {
      logic [19:0] s;
      logic [63:0] d;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [15:0] exp_fw = '0;
   logic [63:0] exp_fd = '0;

   frame_config_sequencer_if #(.W(32)) bus ();

   frame_config_sequencer dut (
      .CLK            (clk),
      .reset          (reset),
      .cfg            (bus),
      .FrameData      (FrameData),
      .FrameStrobe    (FrameStrobe),
      .busy           (busy),
      .frames_written (frames_written),
      .err_sync       (err_sync),
      .err_range      (err_range),
      .err_clr        (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one word after 'gaps' idle cycles; returns #1 after the accepting edge
   task automatic put(input logic [31:0] w, input int gaps);
      bit ok;
      ok = 1'b0;
      if (gaps > 0) begin
         bus.cfg_valid = 1'b0;
         bus.cfg_word  = $urandom;
         repeat (gaps) @(posedge clk);
         #1;
      end
      bus.cfg_word  = w;
      bus.cfg_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.cfg_ready === 1'b1) ok = 1'b1;
         tick();
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic send(input logic [31:0] hdr, input logic [31:0] a, input logic [31:0] b,
                       input int gh, input int ga, input int gb);
      put(hdr, gh);
      put(a, ga);
      put(b, gb);
      bus.cfg_valid = 1'b0;
   endtask

   task automatic post_frame(input logic [19:0] strobe);
      exp_fw = exp_fw + 16'd1;
      @(negedge clk);
      check("strobe_cycle", 64'(FrameStrobe), 64'(strobe));
      check("ready_in_strobe", 64'(bus.cfg_ready), 64'd0);
      @(negedge clk);
      check("strobe_one_cycle", 64'(FrameStrobe), 64'd0);
      check("ready_in_hold", 64'(bus.cfg_ready), 64'd0);
      check("busy_in_hold", 64'(busy), 64'd1);
      @(negedge clk);
      check("ready_after_hold", 64'(bus.cfg_ready), 64'd1);
      check("busy_after_hold", 64'(busy), 64'd0);
      check("frames_written", 64'(frames_written), 64'(exp_fw));
      check("frame_data_held", FrameData, exp_fd);
      tick();
   endtask

   task automatic check_reset_state();
      check("rst_frame_data", FrameData, 64'd0);
      check("rst_strobe", 64'(FrameStrobe), 64'd0);
      check("rst_frames_written", 64'(frames_written), 64'd0);
      check("rst_err_sync", 64'(err_sync), 64'd0);
      check("rst_err_range", 64'(err_range), 64'd0);
      check("rst_ready", 64'(bus.cfg_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
   endtask

   // scoreboard: every strobe cycle must match the next queued frame
   always @(negedge clk) begin
      if (FrameStrobe !== 20'd0) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", 64'(FrameStrobe), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("sb_strobe", 64'(FrameStrobe), 64'(mon_e.s));
            check("sb_frame_data", FrameData, mon_e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cfg_valid = 1'b0;
      bus.cfg_word  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_state();
      tick();

      // back-to-back frame idx 3
      exp_fd = {32'h3333_4444, 32'h1111_2222};
      sb.push_back('{s: 20'h00008, d: exp_fd});
      send(32'hFA03_0000, 32'h1111_2222, 32'h3333_4444, 0, 0, 0);
      post_frame(20'h00008);

      // bad sync byte dropped, then a good frame idx 0
      put(32'h1203_0000, 0);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      check("bad_sync_err", 64'(err_sync), 64'd1);
      check("bad_sync_busy", 64'(busy), 64'd0);
      check("bad_sync_fw", 64'(frames_written), 64'(exp_fw));
      tick();
      exp_fd = {32'hCAFE_0002, 32'hBEEF_0001};
      sb.push_back('{s: 20'h00001, d: exp_fd});
      send(32'hFA00_0000, 32'hBEEF_0001, 32'hCAFE_0002, 0, 0, 0);
      post_frame(20'h00001);
      check("err_sync_sticky", 64'(err_sync), 64'd1);

      // out-of-range index drains two words without touching the frame
      send(32'hFA14_0000, 32'hDEAD_0001, 32'hDEAD_0002, 0, 0, 0);
      @(negedge clk);
      check("range_err", 64'(err_range), 64'd1);
      check("range_busy", 64'(busy), 64'd0);
      check("range_frame_data", FrameData, exp_fd);
      check("range_fw", 64'(frames_written), 64'(exp_fw));
      tick();

      // valid toggles 1-0-0-1-0-1
      exp_fd = {32'h3333_4444, 32'h1111_2222};
      sb.push_back('{s: 20'h00008, d: exp_fd});
      send(32'hFA03_0000, 32'h1111_2222, 32'h3333_4444, 0, 2, 1);
      post_frame(20'h00008);

      // reset after header + one data word
      put(32'hFA05_0000, 0);
      put(32'h5555_0001, 0);
      bus.cfg_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_reset_state();
      tick();
      exp_fw = '0;
      exp_fd = {32'h7777_8888, 32'h5555_6666};
      sb.push_back('{s: 20'h80000, d: exp_fd});
      send(32'hFA13_0000, 32'h5555_6666, 32'h7777_8888, 0, 0, 0);
      post_frame(20'h80000);

      // set-wins against err_clr, then clear alone
      send(32'hFA20_0000, 32'h0, 32'h0, 0, 0, 0);
      @(negedge clk);
      check("range_err_idx32", 64'(err_range), 64'd1);
      tick();
      err_clr = 1'b1;
      put(32'hAB00_0000, 0);
      bus.cfg_valid = 1'b0;
      @(negedge clk);
      check("clr_vs_set_sync", 64'(err_sync), 64'd1);
      check("clr_range", 64'(err_range), 64'd0);
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("clr_alone_sync", 64'(err_sync), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
